// File: rtl/fetch_unit_if.sv
// fetch_unit_if: MEMI read port, redirect inputs and decode handshake of the fetch stage.
`ifndef INST_LEN
`define INST_LEN 32
`endif
`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 8
`endif

interface fetch_unit_if #(
    parameter int INST_LEN      = `INST_LEN,
    parameter int MEMI_SIZE_LOG = `MEMI_SIZE_LOG
);
    logic                     imem_req;
    logic [MEMI_SIZE_LOG-1:0] imem_addr;
    logic [INST_LEN-1:0]      imem_rdata;
    logic                     redirect_valid;
    logic [MEMI_SIZE_LOG-1:0] redirect_pc;
    logic                     br_resolved;
    logic                     out_valid;
    logic [INST_LEN-1:0]      out_inst;
    logic [MEMI_SIZE_LOG-1:0] out_pc;
    logic                     out_ready;

    modport master (
        output imem_req, imem_addr, out_valid, out_inst, out_pc,
        input  imem_rdata, redirect_valid, redirect_pc, br_resolved, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_inst, out_pc,
        output imem_rdata, redirect_valid, redirect_pc, br_resolved, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC, one-cycle MEMI reads and a circular fetch queue feeding decode.
// FETCH_BR_STALL_EN: after a branch is pushed, hold fetch until br_resolved or redirect.
`ifndef INST_LEN
`define INST_LEN 32
`endif
`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 8
`endif
`ifndef INST_OP_BR
`define INST_OP_BR 7'h63
`endif

module fetch_unit #(
    parameter int                       INST_LEN      = `INST_LEN,
    parameter int                       MEMI_SIZE_LOG = `MEMI_SIZE_LOG,
    parameter int                       FQ_DEPTH      = 2,
    parameter logic [MEMI_SIZE_LOG-1:0] RESET_PC      = '0
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    typedef logic [PW-1:0] ptr_t;

    logic [MEMI_SIZE_LOG-1:0] pc_q, pc_d, ipc_q;
    logic                     infl_q;
    logic [CW-1:0]            cnt_q, cnt_d;
    ptr_t                     head_q, head_d, tail_q, tail_d;
    logic [INST_LEN-1:0]      inst_q [FQ_DEPTH];
    logic [MEMI_SIZE_LOG-1:0] pcs_q [FQ_DEPTH];
    logic                     valid, pop, push, req, stall;

    function automatic ptr_t inc(input ptr_t p);
        return (int'(p) == FQ_DEPTH - 1) ? '0 : p + ptr_t'(1);
    endfunction

    // Occupancy counts the in-flight response so the queue can never overflow.
    always_comb begin
        valid  = cnt_q != '0;
        pop    = valid && bus.out_ready;
        push   = infl_q && !bus.redirect_valid;
        req    = rst_n && !bus.redirect_valid && !stall
                 && (int'(cnt_q) + int'(infl_q) - int'(pop) < FQ_DEPTH);
        pc_d   = bus.redirect_valid ? bus.redirect_pc : req ? pc_q + 1'b1 : pc_q;
        head_d = bus.redirect_valid ? '0 : pop ? inc(head_q) : head_q;
        tail_d = bus.redirect_valid ? '0 : push ? inc(tail_q) : tail_q;
        cnt_d  = bus.redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

`ifdef FETCH_BR_STALL_EN
    logic br_q, br_d, br_push;

    always_comb begin
        br_push = push && bus.imem_rdata[6:0] == `INST_OP_BR;
        stall   = br_q || br_push;
        br_d    = bus.redirect_valid ? 1'b0 : br_push ? 1'b1 : bus.br_resolved ? 1'b0 : br_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) br_q <= 1'b0;
        else        br_q <= br_d;
    end
`else
    logic unused_br;
    assign stall     = 1'b0;
    assign unused_br = bus.br_resolved;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            infl_q <= 1'b0;
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            assert (!(push && !pop && int'(cnt_q) == FQ_DEPTH));
            pc_q   <= pc_d;
            infl_q <= req;
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        ipc_q <= pc_q;
        if (push) begin
            inst_q[tail_q] <= bus.imem_rdata;
            pcs_q[tail_q]  <= ipc_q;
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = valid;
    assign bus.out_inst  = valid ? inst_q[head_q] : '0;
    assign bus.out_pc    = valid ? pcs_q[head_q] : '0;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Holds the PC and issues one-cycle-latency reads to instruction memory (MEMI).
- Buffers returned instructions in a small queue and presents them to decode over a valid/ready handshake.
- Handles redirect (squash plus new PC) from the back end; sustains 1 inst/cycle when decode is always ready.

Parameters:
- INST_LEN, default `INST_LEN, instruction width in bits.
- MEMI_SIZE_LOG, default `MEMI_SIZE_LOG, PC/MEMI address width.
- FQ_DEPTH, default 2, fetch-queue entries (≥2).
- RESET_PC, default 0, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  MEMI_SIZE_LOG  read address (current PC).
- imem_rdata  in  INST_LEN  read data; valid exactly one cycle after imem_req.
- redirect_valid  in  1  squash all in-flight/queued fetches and restart.
- redirect_pc  in  MEMI_SIZE_LOG  restart PC.
- br_resolved  in  1  back end resolved the oldest outstanding branch; used only with FETCH_BR_STALL_EN.
- out_valid  out  1  queue head valid for decode.
- out_inst  out  INST_LEN  head instruction, fed to decode inst.
- out_pc  out  MEMI_SIZE_LOG  head instruction's PC.
- out_ready  in  1  decode accepts head this cycle.

Behaviour:
- Reset (rst_n=0 at edge):
  - pc←RESET_PC; queue empty; inflight←0.
  - Outputs next cycle: imem_req=0, out_valid=0, out_inst=0, out_pc=0.
  - Reset mid-operation discards all in-flight and queued state.
- Pop: pop = out_valid && out_ready. out_inst/out_pc are stable while out_valid && !out_ready.
- Request rule (combinational): imem_req = !redirect_valid && !stall && (count + inflight − pop < FQ_DEPTH). When imem_req=1: imem_addr=pc; pc←pc+1, wrapping modulo 2^MEMI_SIZE_LOG.
- Response:
  - inflight←imem_req each cycle, with inflight_pc←pc.
  - When inflight=1, imem_rdata and inflight_pc are pushed into the queue at that cycle's edge.
- Latency: request in cycle N → out_valid in cycle N+2 (queue empty case). Back-to-back requests give out_valid continuously with PCs N, N+1, N+2… when out_ready=1.
- Queue: circular, FQ_DEPTH entries. Push and pop in the same cycle are legal, including when full (pop frees the slot). Overflow is impossible by the request rule; assert in simulation.
- Redirect (highest priority):
  - Flush the queue (count←0).
  - Drop any response arriving that cycle (no push).
  - pc←redirect_pc; no request that cycle.
  - out_valid is 0 in cycle R+1.
  - First request at redirect_pc in R+1; its instruction reaches out_valid in R+3.
  - A pop coinciding with redirect is still taken by decode but its result is squashed downstream.
- Reset overrides redirect.
- Wrap: pc = 2^MEMI_SIZE_LOG−1 fetches, then pc←0.

Optional Feature:
- FETCH_BR_STALL_EN.
- Defined:
  - Pre-decode each pushed instruction's opcode field. If it equals `INST_OP_BR, set br_pending←1.
  - While br_pending (or a BR is being pushed this cycle), stall=1: no new requests.
  - br_resolved clears br_pending.
  - redirect_valid also clears br_pending.
  - Fetch resumes the cycle after the clear.
  - Guarantees no speculative fetch past a branch.
- Undefined: stall=0 always; br_resolved is ignored; fetch proceeds sequentially past branches.

Test Plan:
- Reset release, out_ready=1, MEMI[i]=i+0x10 → imem_req from cycle 0. out_valid first at cycle 2 with out_pc=0, out_inst=0x10. Then PCs 1,2,3 on consecutive cycles.
- out_ready=0 for 5 cycles after the first valid → queue fills to 2 and imem_req drops. out_pc holds 0. On out_ready=1, PCs 0,1,2… follow with no gap or duplicate.
- redirect_valid=1 with redirect_pc=9 while the queue holds 2 and a request is in flight → out_valid=0 next cycle. imem_addr=9 next cycle. Next delivered out_pc=9; no stale PCs appear.
- Start pc = 2^MEMI_SIZE_LOG−2, out_ready=1 → delivered PCs max−1, max, 0, 1.
- With FETCH_BR_STALL_EN, MEMI[3]=BR → after fetching pc 3, imem_req stays 0. After br_resolved pulse, the next request has imem_addr=4. Without the macro, pc 4 is fetched the cycle after 3.
- rst_n=0 mid-stream with the queue full → next cycle out_valid=0, imem_req=0. After release, fetch restarts at RESET_PC.
